// File: rtl/serial_to_3par_pkg.sv
// rtl/serial_to_3par_pkg.sv - shared constants and phase encoding for the 3-lane packer
package serial_to_3par_pkg;

   localparam int NBIT_DEFAULT = 10;
   localparam int LANES        = 3;

   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2
   } ph_t;

endpackage

// File: rtl/serial_to_3par.sv
// rtl/serial_to_3par.sv - packs three serial samples into one block for the 3-parallel FIR
module serial_to_3par
   import serial_to_3par_pkg::*;
#(
   parameter int NBIT = NBIT_DEFAULT
) (
   input  logic            CLK,
   input  logic            RST_n,
   input  logic [NBIT-1:0] Din,
   input  logic            Vin,
   input  logic            Flush,
   output logic [NBIT-1:0] Dout3k,
   output logic [NBIT-1:0] Dout3k1,
   output logic [NBIT-1:0] Dout3k2,
   output logic            Vout
);

   ph_t             ph;
   ph_t             ph_next;
   logic [NBIT-1:0] s0;
   logic [NBIT-1:0] s1;
   logic [NBIT-1:0] lane0;
   logic [NBIT-1:0] lane1;
   logic [NBIT-1:0] lane2;
   logic            emit;

   // A sample arriving with Flush is taken into the block before it is closed.
   always_comb begin
      ph_next = ph;
      emit    = 1'b0;
      lane0   = s0;
      lane1   = '0;
      lane2   = '0;
      case (ph)
         PH0: begin
            lane0 = Din;
            if (Vin) begin
               ph_next = PH1;
               emit    = Flush;
            end
         end
         PH1: begin
            lane1 = Vin ? Din : '0;
            if (Vin) ph_next = PH2;
            emit = Flush;
         end
         PH2: begin
            lane1 = s1;
            lane2 = Vin ? Din : '0;
            emit  = Vin | Flush;
         end
         default: ph_next = PH0;
      endcase
      if (emit) ph_next = PH0;
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         ph <= PH0;
         s0 <= '0;
         s1 <= '0;
      end else begin
         ph <= ph_next;
         if (Vin && ph == PH0) s0 <= Din;
         if (Vin && ph == PH1) s1 <= Din;
      end
   end

   // Lanes only change on an emit so the filter can sample them any time Vout is high.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         Dout3k  <= '0;
         Dout3k1 <= '0;
         Dout3k2 <= '0;
         Vout    <= 1'b0;
      end else begin
         Vout <= emit;
         if (emit) begin
            Dout3k  <= lane0;
            Dout3k1 <= lane1;
            Dout3k2 <= lane2;
         end
      end
   end

endmodule

// File: tb/tb_serial_to_3par.sv
// tb/tb_serial_to_3par.sv - self-checking bench for serial_to_3par with a queue-based reference model
module tb_serial_to_3par;
   import serial_to_3par_pkg::*;

   localparam int NBIT = NBIT_DEFAULT;

   logic            CLK;
   logic            RST_n;
   logic [NBIT-1:0] Din;
   logic            Vin;
   logic            Flush;
   logic [NBIT-1:0] Dout3k;
   logic [NBIT-1:0] Dout3k1;
   logic [NBIT-1:0] Dout3k2;
   logic            Vout;

   int checks   = 0;
   int failures = 0;

   logic [NBIT-1:0] pend[$];
   logic [NBIT-1:0] m_lane[LANES];
   logic            m_v;

   serial_to_3par #(.NBIT(NBIT)) dut (
      .CLK(CLK), .RST_n(RST_n), .Din(Din), .Vin(Vin), .Flush(Flush),
      .Dout3k(Dout3k), .Dout3k1(Dout3k1), .Dout3k2(Dout3k2), .Vout(Vout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [3*NBIT:0] obs();
      return {Vout, Dout3k, Dout3k1, Dout3k2};
   endfunction

   function automatic logic [3*NBIT:0] model_vec();
      return {m_v, m_lane[0], m_lane[1], m_lane[2]};
   endfunction

   function automatic void model_reset();
      pend.delete();
      m_v = 1'b0;
      for (int i = 0; i < LANES; i++) m_lane[i] = '0;
   endfunction

   // A block closes when it holds three samples, or on Flush when it holds any.
   task automatic drive(input logic [NBIT-1:0] d, input logic v, input logic f);
      Din = d; Vin = v; Flush = f;
      @(posedge CLK); #1;
      m_v = 1'b0;
      if (v) pend.push_back(d);
      if (pend.size() == LANES || (f && pend.size() != 0)) begin
         for (int i = 0; i < LANES; i++) m_lane[i] = (i < pend.size()) ? pend[i] : '0;
         m_v = 1'b1;
         pend.delete();
      end
   endtask

   task automatic test_reset();
      Din = '0; Vin = 1'b0; Flush = 1'b0; RST_n = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (obs() !== '0) begin
         failures++;
         $display("FAIL reset_state got=%h want=0", obs());
      end
      RST_n = 1'b1;
      drive('0, 1'b0, 1'b0);
   endtask

   task automatic test_continuous();
      logic [3*NBIT:0] exp;
      int base;
      for (int i = 1; i <= 6; i++) begin
         drive(NBIT'(i), 1'b1, 1'b0);
         base = (i / 3) * 3;
         exp = (base == 0) ? '0 : {1'b0, NBIT'(base - 2), NBIT'(base - 1), NBIT'(base)};
         exp[3*NBIT] = (i % 3 == 0);
         checks++;
         if (obs() !== exp) begin
            failures++;
            $display("FAIL continuous cycle=%0d got=%h want=%h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_gaps_extremes();
      logic [NBIT-1:0] seq_d[7] = '{10'h200, 10'h000, 10'h1FF, 10'h000, 10'h3FF, 10'h000, 10'h000};
      logic            seq_v[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3*NBIT:0] exp;
      for (int i = 0; i < 7; i++) begin
         drive(seq_d[i], seq_v[i], 1'b0);
         if (i < 4) exp = {1'b0, 10'd4, 10'd5, 10'd6};
         else       exp = {(i == 4), 10'h200, 10'h1FF, 10'h3FF};
         checks++;
         if (obs() !== exp) begin
            failures++;
            $display("FAIL gaps_extremes step=%0d got=%h want=%h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_flush_partial();
      drive(10'd7, 1'b1, 1'b0);
      drive(10'd8, 1'b1, 1'b0);
      drive(10'd0, 1'b0, 1'b1);
      checks++;
      if (obs() !== {1'b1, 10'd7, 10'd8, 10'd0}) begin
         failures++;
         $display("FAIL flush_ph2 got=%h want=%h", obs(), {1'b1, 10'd7, 10'd8, 10'd0});
      end
      drive(10'd9, 1'b1, 1'b0);
      drive(10'd10, 1'b1, 1'b0);
      drive(10'd11, 1'b1, 1'b0);
      checks++;
      if (obs() !== {1'b1, 10'd9, 10'd10, 10'd11}) begin
         failures++;
         $display("FAIL after_flush got=%h want=%h", obs(), {1'b1, 10'd9, 10'd10, 10'd11});
      end
      drive(10'd12, 1'b1, 1'b0);
      drive(10'd0, 1'b0, 1'b1);
      checks++;
      if (obs() !== {1'b1, 10'd12, 10'd0, 10'd0}) begin
         failures++;
         $display("FAIL flush_ph1 got=%h want=%h", obs(), {1'b1, 10'd12, 10'd0, 10'd0});
      end
   endtask

   task automatic test_back_to_back();
      drive(10'd5, 1'b1, 1'b1);
      checks++;
      if (obs() !== {1'b1, 10'd5, 10'd0, 10'd0}) begin
         failures++;
         $display("FAIL vin_flush_ph0 got=%h want=%h", obs(), {1'b1, 10'd5, 10'd0, 10'd0});
      end
      drive(10'd0, 1'b0, 1'b1);
      checks++;
      if (obs() !== {1'b0, 10'd5, 10'd0, 10'd0}) begin
         failures++;
         $display("FAIL flush_idle_ph0 got=%h want=%h", obs(), {1'b0, 10'd5, 10'd0, 10'd0});
      end
      drive(10'd6, 1'b1, 1'b1);
      drive(10'd7, 1'b1, 1'b1);
      checks++;
      if (obs() !== {1'b1, 10'd7, 10'd0, 10'd0}) begin
         failures++;
         $display("FAIL back_to_back got=%h want=%h", obs(), {1'b1, 10'd7, 10'd0, 10'd0});
      end
      drive(10'd1, 1'b1, 1'b0);
      drive(10'd2, 1'b1, 1'b1);
      checks++;
      if (obs() !== {1'b1, 10'd1, 10'd2, 10'd0}) begin
         failures++;
         $display("FAIL vin_flush_ph1 got=%h want=%h", obs(), {1'b1, 10'd1, 10'd2, 10'd0});
      end
   endtask

   task automatic test_mid_reset();
      drive(10'd1, 1'b1, 1'b0);
      drive(10'd2, 1'b1, 1'b0);
      drive(10'd3, 1'b1, 1'b0);
      drive(10'd1, 1'b1, 1'b0);
      drive(10'd2, 1'b1, 1'b0);
      #2 RST_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs() !== '0) begin
         failures++;
         $display("FAIL async_reset got=%h want=0", obs());
      end
      Vin = 1'b0;
      @(posedge CLK); #1;
      RST_n = 1'b1;
      drive(10'd3, 1'b1, 1'b0);
      drive(10'd4, 1'b1, 1'b0);
      checks++;
      if (obs() !== '0) begin
         failures++;
         $display("FAIL reset_discard got=%h want=0", obs());
      end
      drive(10'd5, 1'b1, 1'b0);
      checks++;
      if (obs() !== {1'b1, 10'd3, 10'd4, 10'd5}) begin
         failures++;
         $display("FAIL post_reset_block got=%h want=%h", obs(), {1'b1, 10'd3, 10'd4, 10'd5});
      end
   endtask

   task automatic test_random();
      int sent = 0;
      int cyc  = 0;
      logic v, f;
      while (sent < 3000 && cyc < 20000) begin
         v = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 31) == 0);
         drive(NBIT'($urandom), v, f);
         if (v) sent++;
         cyc++;
         checks++;
         if (obs() !== model_vec()) begin
            failures++;
            $display("FAIL random cycle=%0d got=%h want=%h", cyc, obs(), model_vec());
         end
      end
      checks++;
      if (sent != 3000) begin
         failures++;
         $display("FAIL random_budget sent=%0d want=3000", sent);
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_gaps_extremes();
      test_flush_partial();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_to_3par.md
# serial_to_3par

Serial-to-parallel packer that feeds the 3-parallel FIR filter (`myfilter`). It accepts one NBIT-bit sample per valid cycle and groups three consecutive samples x[3k], x[3k+1], x[3k+2] into one block. Each block is presented on three lanes with a single-cycle valid pulse, which drives the filter's Din3k/Din3k1/Din3k2/Vin inputs directly. A flush input closes a partial block at end of stream, zero-padding the missing lanes.

## Interface
- NBIT, 10, sample width in bits (two's complement); must match the filter's NBIT.
- CLK  in  1  single system clock; all state updates on the rising edge.
- RST_n  in  1  reset, asynchronous and active-low; clears all state immediately.
- Din  in  NBIT  serial input sample.
- Vin  in  1  Din valid; the sample is consumed on every rising edge where Vin=1.
- Flush  in  1  close the current partial block; zero-pad its missing lanes.
- Dout3k  out  NBIT  lane 0, sample x[3k]; goes to filter Din3k.
- Dout3k1  out  NBIT  lane 1, sample x[3k+1]; goes to filter Din3k1.
- Dout3k2  out  NBIT  lane 2, sample x[3k+2]; goes to filter Din3k2.
- Vout  out  1  one-cycle pulse marking a new block on Dout*; goes to filter Vin.

## Operation
- Phase counter `ph` takes values 0, 1 and 2 only; 3 never occurs. Two staging registers S0 and S1. Three output registers, one per Dout lane. Vout is a register.
- Vin=1 with ph=0: S0 <= Din; ph <= 1.
- Vin=1 with ph=1: S1 <= Din; ph <= 2.
- Vin=1 with ph=2: outputs load {S0, S1, Din}; Vout <= 1; ph <= 0.
- Vin=0 and Flush=0: ph, S0, S1 and all outputs hold; Vout <= 0.
- Flush=1 with Vin=0:
  - ph=1: outputs load {S0, 0, 0}; Vout <= 1; ph <= 0.
  - ph=2: outputs load {S0, S1, 0}; Vout <= 1; ph <= 0.
  - ph=0: no effect; Vout <= 0.
- Flush=1 and Vin=1 in the same cycle: the sample is taken first, then the flush applies.
  - ph=0: emit {Din, 0, 0}.
  - ph=1: emit {S0, Din, 0}.
  - ph=2: normal full emit {S0, S1, Din}.
  - In every case Vout <= 1 and ph <= 0.
- No data arithmetic. Samples pass through bit-exact. Zero padding is all-zero NBIT.
- Vout is never asserted two cycles in a row except by back-to-back emits, which require Vin on every cycle. The minimum full-block period is 3 cycles. Flush can shorten it: Vin+Flush on consecutive cycles gives back-to-back Vout.
- Samples are not stored in the output registers until a block completes. S0 and S1 are not cleared after an emit; they are overwritten by the next block.

## Timing
- Reset (RST_n=0, asynchronous): ph=0, S0=S1=0, Dout3k=Dout3k1=Dout3k2=0, Vout=0. A partial block in progress is discarded.
- Latency: the third sample of a block is sampled at edge n. Dout* and Vout=1 are visible after edge n, for the cycle n..n+1. The block pulse comes 2 cycles after the first sample's edge when Vin is continuous.
- Dout* hold their value until the next emit, so the filter may sample them in any cycle while Vout=1.
- Vin gaps of any length inside a block are allowed. The phase is preserved across gaps.
- Releasing RST_n: the first sample accepted after release is lane 0 of a new block.

## Structure
- Shared package/header holds NBIT_DEFAULT=10, the phase encoding PH0/PH1/PH2 (2 bits) and LANES=3. The filter and its testbench use the same package.
- No sub-module. The block is one always block for state/staging plus one for the output registers. Expected size is about 120–160 lines.
- The filter testbench gains this block between data_maker (serial mode) and myfilter.

## Test plan
- Reset, then Vin=1 continuously with Din=1, 2, 3, 4, 5, 6 → Vout pulses on cycles 3 and 6 with {1,2,3} and {4,5,6}. Vout=0 on all other cycles.
- Din=-512, 511, -1 with one idle cycle between each sample → a single Vout carrying {0x200, 0x1FF, 0x3FF}. Outputs hold until the next block.
- Samples 7, 8, then Flush=1 with Vin=0 → Vout=1 with {7, 8, 0}; the next sample 9 appears on lane 0 of the following block.
- Vin=1 and Flush=1 together at ph=0 with Din=5 → {5, 0, 0}, Vout=1. Flush alone at ph=0 → no Vout.
- Samples 1, 2, then RST_n pulsed low mid-cycle → all outputs go to 0 immediately. The next samples 3, 4, 5 emit {3, 4, 5}.
- 3000 random samples with random Vin gaps, compared against a reference model → every emitted lane matches x[3k+i] exactly.
